// File: rtl/mult_stall_controller_if.sv
// rtl/mult_stall_controller_if.sv - EX-stage multiply handshake bundle (perf ports under MULT_STALL_PERF_CNT_EN)
interface mult_stall_controller_if;
  logic        idex_is_mult;
  logic        ext_stall;
  logic        global_enable;
  logic        mult_start;
  logic        mult_busy;
  logic        mult_result_sel;
`ifdef MULT_STALL_PERF_CNT_EN
  logic        perf_clr;
  logic [31:0] stall_cycles;

  modport master (
    output idex_is_mult, ext_stall, perf_clr,
    input  global_enable, mult_start, mult_busy, mult_result_sel, stall_cycles
  );
  modport slave (
    input  idex_is_mult, ext_stall, perf_clr,
    output global_enable, mult_start, mult_busy, mult_result_sel, stall_cycles
  );
`else
  modport master (
    output idex_is_mult, ext_stall,
    input  global_enable, mult_start, mult_busy, mult_result_sel
  );
  modport slave (
    input  idex_is_mult, ext_stall,
    output global_enable, mult_start, mult_busy, mult_result_sel
  );
`endif
endinterface

// File: rtl/mult_stall_controller.sv
// rtl/mult_stall_controller.sv - Multiplier sequencer and pipeline freeze; optional stall counter under MULT_STALL_PERF_CNT_EN
module mult_stall_controller #(
  parameter int MULT_LATENCY = 4,
  parameter int CNT_W        = 4
) (
  input logic                    clk,
  input logic                    rst,
  mult_stall_controller_if.slave bus
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             start_ok;
  logic             ge_c;
  logic             start_c;
  logic             busy_c;
  logic             sel_c;

  // A multiply may only launch from IDLE while nothing else holds the pipeline.
  assign start_ok = (state == IDLE) && bus.idex_is_mult && !bus.ext_stall;

  // Output decode; reset forces every output low, including the advance enable.
  always_comb begin
    ge_c    = 1'b0;
    start_c = 1'b0;
    busy_c  = 1'b0;
    sel_c   = 1'b0;
    if (!rst) begin
      unique case (state)
        IDLE: begin
          ge_c = !bus.ext_stall;
          if (start_ok) begin
            start_c = 1'b1;
            busy_c  = 1'b1;
            ge_c    = 1'b0;
          end
        end
        BUSY: begin
          busy_c = 1'b1;
        end
        DONE: begin
          sel_c = 1'b1;
          ge_c  = !bus.ext_stall;
        end
        default: begin
          ge_c = 1'b0;
        end
      endcase
    end
  end

  assign bus.global_enable   = ge_c;
  assign bus.mult_start      = start_c;
  assign bus.mult_busy       = busy_c;
  assign bus.mult_result_sel = sel_c;

  // Sequencer: the counter runs even under ext_stall since the multiplier itself never stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start_ok) begin
            state <= BUSY;
            cnt   <= CNT_W'(MULT_LATENCY - 1);
          end
        end
        BUSY: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state <= DONE;
          end
        end
        DONE: begin
          if (!bus.ext_stall) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

`ifdef MULT_STALL_PERF_CNT_EN
  logic [31:0] stall_cnt;

  // Counts cycles lost to multiplies; clear wins over a same-cycle increment.
  always_ff @(posedge clk) begin
    if (rst || bus.perf_clr) begin
      stall_cnt <= '0;
    end else if ((state == BUSY) || start_c) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign bus.stall_cycles = stall_cnt;
`endif

endmodule

// File: tb/tb_mult_stall_controller.sv
// tb/tb_mult_stall_controller.sv - Self-checking bench for mult_stall_controller (latencies 4 and 2)
module tb_mult_stall_controller;

  logic clk;
  logic rst;
  logic mult;
  logic ext;
  logic pclr;
  int   checks;
  int   errors;

  mult_stall_controller_if if4 ();
  mult_stall_controller_if if2 ();

  assign if4.idex_is_mult = mult;
  assign if4.ext_stall    = ext;
  assign if2.idex_is_mult = mult;
  assign if2.ext_stall    = ext;
`ifdef MULT_STALL_PERF_CNT_EN
  assign if4.perf_clr = pclr;
  assign if2.perf_clr = pclr;
`endif

  mult_stall_controller #(.MULT_LATENCY(4), .CNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (if4.slave)
  );

  mult_stall_controller #(.MULT_LATENCY(2), .CNT_W(2)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (if2.slave)
  );

  // Observed outputs packed as {global_enable, mult_start, mult_busy, mult_result_sel}
  logic [3:0] obs4;
  logic [3:0] obs2;
  assign obs4 = {if4.global_enable, if4.mult_start, if4.mult_busy, if4.mult_result_sel};
  assign obs2 = {if2.global_enable, if2.mult_start, if2.mult_busy, if2.mult_result_sel};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; mult = 1'b1; ext = 1'b0; pclr = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++;
      if (obs4 !== 4'b0000 || obs2 !== 4'b0000) begin
        errors++;
        $display("FAIL reset k=%0d got4=%b got2=%b exp=0000", k, obs4, obs2);
      end
      next_cycle();
    end
    rst = 1'b0; mult = 1'b0;
    @(negedge clk);
    checks++;
    if (obs4 !== 4'b1000) begin
      errors++;
      $display("FAIL reset_idle got=%b exp=1000", obs4);
    end
    next_cycle();
  endtask

  task automatic test_single_mul();
    logic [3:0] e;
    for (int k = 0; k < 6; k++) begin
      mult = (k == 0);
      ext  = 1'b0;
      e = {(k >= 4), (k == 0), (k <= 3), (k == 4)};
      @(negedge clk);
      checks++;
      if (obs4 !== e) begin
        errors++;
        $display("FAIL single k=%0d got=%b exp=%b", k, obs4, e);
      end
      next_cycle();
    end
    mult = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [3:0] e;
    for (int k = 0; k < 15; k++) begin
      mult = 1'b1;
      ext  = 1'b0;
      e = {(k % 5 == 4), (k % 5 == 0), (k % 5 <= 3), (k % 5 == 4)};
      @(negedge clk);
      checks++;
      if (obs4 !== e) begin
        errors++;
        $display("FAIL b2b k=%0d got=%b exp=%b", k, obs4, e);
      end
      next_cycle();
    end
    mult = 1'b0;
  endtask

  task automatic test_ext_stall_arrival();
    logic [3:0] e;
    for (int k = 0; k < 9; k++) begin
      mult = (k <= 3);
      ext  = (k <= 2);
      if (k <= 2)      e = 4'b0000;
      else if (k == 3) e = 4'b0110;
      else if (k <= 6) e = 4'b0010;
      else if (k == 7) e = 4'b1001;
      else             e = 4'b1000;
      @(negedge clk);
      checks++;
      if (obs4 !== e) begin
        errors++;
        $display("FAIL ext_arrival k=%0d got=%b exp=%b", k, obs4, e);
      end
      next_cycle();
    end
    mult = 1'b0; ext = 1'b0;
  endtask

  task automatic test_ext_stall_busy_done();
    logic [3:0] e;
    for (int k = 0; k < 8; k++) begin
      mult = (k == 0);
      ext  = (k == 1) || (k == 2) || (k == 4) || (k == 5);
      if (k == 0)      e = 4'b0110;
      else if (k <= 3) e = 4'b0010;
      else if (k <= 5) e = 4'b0001;
      else if (k == 6) e = 4'b1001;
      else             e = 4'b1000;
      @(negedge clk);
      checks++;
      if (obs4 !== e) begin
        errors++;
        $display("FAIL ext_busy_done k=%0d got=%b exp=%b", k, obs4, e);
      end
      next_cycle();
    end
    mult = 1'b0; ext = 1'b0;
  endtask

  task automatic test_reset_mid_busy();
    logic [3:0] e;
    for (int k = 0; k < 10; k++) begin
      mult = (k == 0);
      ext  = 1'b0;
      rst  = (k == 2);
      if (k == 0)      e = 4'b0110;
      else if (k == 1) e = 4'b0010;
      else if (k == 2) e = 4'b0000;
      else             e = 4'b1000;
      @(negedge clk);
      checks++;
      if (obs4 !== e) begin
        errors++;
        $display("FAIL reset_mid k=%0d got=%b exp=%b", k, obs4, e);
      end
      next_cycle();
    end
    rst = 1'b0; mult = 1'b0;
  endtask

`ifdef MULT_STALL_PERF_CNT_EN
  task automatic test_perf_counter();
    pclr = 1'b1; mult = 1'b0; ext = 1'b0;
    next_cycle();
    pclr = 1'b0;
    for (int m = 0; m < 2; m++) begin
      for (int k = 0; k < 7; k++) begin
        mult = (k == 0);
        next_cycle();
      end
    end
    mult = 1'b0;
    @(negedge clk);
    checks++;
    if (if4.stall_cycles !== 32'd8 || if2.stall_cycles !== 32'd4) begin
      errors++;
      $display("FAIL perf_two got4=%0d got2=%0d exp 8/4", if4.stall_cycles, if2.stall_cycles);
    end
    next_cycle();
    pclr = 1'b1;
    next_cycle();
    pclr = 1'b0;
    @(negedge clk);
    checks++;
    if (if4.stall_cycles !== 32'd0 || if2.stall_cycles !== 32'd0) begin
      errors++;
      $display("FAIL perf_clear got4=%0d got2=%0d exp 0/0", if4.stall_cycles, if2.stall_cycles);
    end
    next_cycle();
    pclr = 1'b1; mult = 1'b1;
    next_cycle();
    pclr = 1'b0; mult = 1'b0;
    @(negedge clk);
    checks++;
    if (if4.stall_cycles !== 32'd0 || if2.stall_cycles !== 32'd0) begin
      errors++;
      $display("FAIL perf_clr_priority got4=%0d got2=%0d exp 0/0", if4.stall_cycles, if2.stall_cycles);
    end
    for (int k = 0; k < 6; k++) next_cycle();
    @(negedge clk);
    checks++;
    if (if4.stall_cycles !== 32'd3 || if2.stall_cycles !== 32'd1) begin
      errors++;
      $display("FAIL perf_after_clr got4=%0d got2=%0d exp 3/1", if4.stall_cycles, if2.stall_cycles);
    end
    next_cycle();
  endtask
`endif

  // Reference: a started multiply freezes the pipeline for LAT cycles, then holds its
  // result select until a cycle with ext_stall low lets it leave.
  task automatic test_random();
    int         frozen_left [2];
    bit         result_hold [2];
    int         stall_cnt   [2];
    int         lat;
    logic [3:0] e;
    logic [3:0] got;
    bit         inc;
    for (int d = 0; d < 2; d++) begin
      frozen_left[d] = 0; result_hold[d] = 1'b0; stall_cnt[d] = 0;
    end
    for (int i = 0; i < 600; i++) begin
      rst  = (i == 0) || ($urandom_range(0, 99) < 2);
      mult = $urandom_range(0, 1);
      ext  = ($urandom_range(0, 3) == 0);
      pclr = ($urandom_range(0, 19) == 0);
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        lat = (d == 0) ? 4 : 2;
        inc = 1'b0;
        if (rst) begin
          e = 4'b0000;
          frozen_left[d] = 0;
          result_hold[d] = 1'b0;
        end else if (result_hold[d]) begin
          e = {!ext, 1'b0, 1'b0, 1'b1};
          if (!ext) result_hold[d] = 1'b0;
        end else if (frozen_left[d] > 0) begin
          e = 4'b0010;
          inc = 1'b1;
          frozen_left[d] = frozen_left[d] - 1;
          if (frozen_left[d] == 0) result_hold[d] = 1'b1;
        end else begin
          e = {!ext, 1'b0, 1'b0, 1'b0};
          if (mult && !ext) begin
            e = 4'b0110;
            inc = 1'b1;
            frozen_left[d] = lat - 1;
          end
        end
        got = (d == 0) ? obs4 : obs2;
        checks++;
        if (got !== e) begin
          errors++;
          $display("FAIL random lat=%0d i=%0d got=%b exp=%b", lat, i, got, e);
        end
`ifdef MULT_STALL_PERF_CNT_EN
        if (i > 0) begin
          checks++;
          if (((d == 0) ? if4.stall_cycles : if2.stall_cycles) !== 32'(stall_cnt[d])) begin
            errors++;
            $display("FAIL random_perf lat=%0d i=%0d got=%0d exp=%0d", lat, i,
                     (d == 0) ? if4.stall_cycles : if2.stall_cycles, stall_cnt[d]);
          end
        end
`endif
        if (rst || pclr) stall_cnt[d] = 0;
        else if (inc)    stall_cnt[d] = stall_cnt[d] + 1;
      end
      next_cycle();
    end
    rst = 1'b0; mult = 1'b0; ext = 1'b0; pclr = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1; mult = 1'b0; ext = 1'b0; pclr = 1'b0;
    #1;
    test_reset();
    test_single_mul();
    test_back_to_back();
    test_ext_stall_arrival();
    test_ext_stall_busy_done();
    test_reset_mid_busy();
`ifdef MULT_STALL_PERF_CNT_EN
    test_perf_counter();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_stall_controller.md
Name: mult_stall_controller

Overview:
- Sequences the multi-cycle multiplier in the EX stage of the 5-stage RISC-V pipeline.
- When a multiply sits in ID/EX, it starts the multiplier and freezes the pipeline for MULT_LATENCY cycles by driving global_enable low.
- global_enable feeds the load-use hazard detection unit, which gates PC_write and IFID_write with it.
- It then selects the multiplier result for exactly one advancing cycle.

Parameters:
MULT_LATENCY, 4, cycles the multiplier needs from mult_start to valid product; legal range 2..15
CNT_W, 4, width of the internal down-counter; must satisfy 2**CNT_W > MULT_LATENCY

Ports:
clk  input  1  pipeline clock; all state updates on rising edge
rst  input  1  synchronous active-high reset
idex_is_mult  input  1  ID/EX holds a valid MUL-class instruction
ext_stall  input  1  external stall request (e.g. data-memory wait); freezes pipeline independent of this block
global_enable  output  1  pipeline advance enable to hazard unit and all pipeline registers
mult_start  output  1  one-cycle start pulse to the multiplier (operands captured this cycle)
mult_busy  output  1  multiplier operation in flight
mult_result_sel  output  1  EX result mux selects multiplier product

Behaviour:
- FSM states: IDLE, BUSY, DONE. Down-counter cnt[CNT_W-1:0]. All outputs are combinational decodes of state, cnt and inputs.
- While rst=1:
  - Outputs are forced: global_enable=0, mult_start=0, mult_busy=0, mult_result_sel=0.
  - Next state is IDLE and cnt is 0.
  - Reset mid-operation abandons the multiply. No pulse or select is issued afterwards.
- IDLE:
  - global_enable = !ext_stall.
  - If idex_is_mult=1 and ext_stall=0: mult_start=1, global_enable=0, mult_busy=1, cnt<=MULT_LATENCY-1, next state BUSY.
  - If idex_is_mult=1 and ext_stall=1: no start; remain IDLE; retry on the next cycle.
- BUSY:
  - global_enable=0, mult_busy=1, mult_start=0.
  - cnt decrements every cycle, including while ext_stall=1; the multiplier is not stalled.
  - When cnt==1, next state is DONE.
- DONE:
  - mult_result_sel=1, mult_busy=0, global_enable = !ext_stall.
  - If ext_stall=0: the pipeline advances and the multiply moves to EX/MEM with its product; next state IDLE.
  - If ext_stall=1: stay in DONE with mult_result_sel held at 1.
- Timing with ext_stall=0: mult_start in cycle T; global_enable low in T..T+MULT_LATENCY-1; DONE in T+MULT_LATENCY with global_enable=1. This gives exactly MULT_LATENCY stall cycles.
- Back-to-back multiplies: DONE->IDLE, then the next cycle starts the following MUL. That is one IDLE cycle with an immediate start; no bubble is inserted beyond MULT_LATENCY.
- idex_is_mult is ignored in BUSY and DONE. The same instruction is never restarted.
- mult_start never asserts in two consecutive cycles.
- mult_busy and mult_result_sel are never simultaneously 1.
- Load-use interaction: the hazard unit keeps priority on NopOut. This block only supplies global_enable and does not inspect load-use conditions.

Optional Feature:
- Macro: MULT_STALL_PERF_CNT_EN.
- Defined:
  - Adds output stall_cycles (32 bits) and input perf_clr (1 bit).
  - stall_cycles increments every cycle the FSM is in BUSY, or in IDLE with mult_start=1; it wraps at 2**32-1 to 0.
  - perf_clr=1 or rst=1 clears stall_cycles to 0. Clear has priority over increment in the same cycle.
- Not defined: neither port exists and no counter logic is synthesised. Core behaviour is identical.

Test Plan:
- Reset then single MUL: rst=1 for 2 cycles, then idex_is_mult=1 at T -> mult_start=1 only at T; global_enable=0 for T..T+3; mult_result_sel=1 and global_enable=1 at T+4; IDLE at T+5.
- Back-to-back MULs, idex_is_mult held 1 continuously -> mult_start at T, T+5, T+10; global_enable high only at T+4 and T+9.
- ext_stall=1 when MUL arrives, for 3 cycles -> no mult_start until ext_stall drops; then the normal 4-cycle sequence.
- ext_stall=1 during BUSY (T+1..T+2) and during DONE (T+4..T+5) -> DONE still entered at T+4; state held with mult_result_sel=1 and global_enable=0 through T+5; advance at T+6.
- rst=1 at T+2 mid-BUSY -> next cycle IDLE, all outputs 0 during reset; no mult_result_sel pulse afterwards.
- With MULT_STALL_PERF_CNT_EN defined: two MULs, MULT_LATENCY=4 -> stall_cycles=8; perf_clr pulse -> 0 next cycle. Repeat with MULT_LATENCY=2 -> stall_cycles=4.
